// File: rtl/uart_receiver_pkg.sv
// UART receiver shared definitions: FSM encoding,
// frame geometry and baud divisor table.
package uart_receiver_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int unsigned OVERSAMPLE_DEF = 16;
  localparam int unsigned DATA_BITS      = 8;

  function automatic int unsigned baud_rate(
    input logic [2:0] sel
  );
    case (sel)
      3'd0:    return 300;
      3'd1:    return 1200;
      3'd2:    return 4800;
      3'd3:    return 9600;
      3'd4:    return 19200;
      3'd5:    return 38400;
      3'd6:    return 57600;
      default: return 115200;
    endcase
  endfunction

  // Rounded clocks per sample tick.
  function automatic int unsigned baud_div(
    input int unsigned clk_hz,
    input int unsigned os,
    input logic [2:0]  sel
  );
    int unsigned d;
    d = os * baud_rate(sel);
    return (clk_hz + d / 2) / d;
  endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Received-byte bundle: data plus valid
// pulse and sticky error flags.
interface uart_receiver_if;
  import uart_receiver_pkg::*;

  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 perror;
  logic                 ferror;

  modport master (
    output data,
    output valid,
    output perror,
    output ferror
  );

  modport slave (
    input data,
    input valid,
    input perror,
    input ferror
  );

endinterface

// File: rtl/baud_controller.sv
// Sample-tick generator: one-cycle pulse
// every round(CLK_HZ/(OVERSAMPLE*baud)) clocks.
module baud_controller
  import uart_receiver_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  output logic       sample_tick
);

  logic [31:0] cnt;
  logic [31:0] div;
  logic [2:0]  sel_q;

  always_comb div = baud_div(CLK_HZ, OVERSAMPLE, baud_select);

  // A rate change restarts the divider phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      sel_q       <= '0;
      sample_tick <= 1'b0;
    end else if (baud_select != sel_q) begin
      cnt         <= '0;
      sel_q       <= baud_select;
      sample_tick <= 1'b0;
    end else if (cnt >= div - 32'd1) begin
      cnt         <= '0;
      sample_tick <= 1'b1;
    end else begin
      cnt         <= cnt + 32'd1;
      sample_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_receiver_fsm.sv
// Frame FSM: start qualify, LSB-first data,
// even parity and stop checks on mid-bit samples.
module uart_receiver_fsm
  import uart_receiver_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sample_tick,
  input  logic            rx_en,
  input  logic            rxd,
  uart_receiver_if.master rx
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
  localparam logic [2:0]    BLST = 3'(DATA_BITS - 1);

  rx_state_t            state, state_n;
  logic [TW-1:0]        tcnt, tcnt_n;
  logic [2:0]           bcnt, bcnt_n;
  logic [DATA_BITS-1:0] sh, sh_n;
  logic [DATA_BITS-1:0] data, data_n;
  logic                 valid, valid_n;
  logic                 perr, perr_n;
  logic                 ferr, ferr_n;
  logic                 rx_d;
  logic                 fall;

  assign fall = rx_d & ~rxd;

  always_comb begin
    state_n = state;
    tcnt_n  = tcnt;
    bcnt_n  = bcnt;
    sh_n    = sh;
    data_n  = data;
    valid_n = 1'b0;
    perr_n  = perr;
    ferr_n  = ferr;
    if (!rx_en) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (fall) begin
            state_n = START;
            tcnt_n  = '0;
          end
        end
        START: begin
          if (sample_tick) begin
            if (tcnt == MID) begin
              tcnt_n = '0;
              if (!rxd) begin
                state_n = DATA;
                bcnt_n  = '0;
                perr_n  = 1'b0;
                ferr_n  = 1'b0;
              end else begin
                state_n = IDLE;
              end
            end else begin
              tcnt_n = tcnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (sample_tick) begin
            if (tcnt == LAST) begin
              tcnt_n = '0;
              sh_n   = {rxd, sh[DATA_BITS-1:1]};
              bcnt_n = bcnt + 3'd1;
              if (bcnt == BLST) state_n = PARITY;
            end else begin
              tcnt_n = tcnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (sample_tick) begin
            if (tcnt == LAST) begin
              tcnt_n  = '0;
              perr_n  = ^{sh, rxd};
              state_n = STOP;
            end else begin
              tcnt_n = tcnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (sample_tick) begin
            if (tcnt == LAST) begin
              tcnt_n = '0;
              if (!rxd) begin
                ferr_n = 1'b1;
              end else if (!perr) begin
                data_n  = sh;
                valid_n = 1'b1;
              end
              // Do not lose a start edge landing on this cycle.
              state_n = fall ? START : IDLE;
            end else begin
              tcnt_n = tcnt + 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      tcnt  <= '0;
      bcnt  <= '0;
      sh    <= '0;
      data  <= '0;
      valid <= 1'b0;
      perr  <= 1'b0;
      ferr  <= 1'b0;
      rx_d  <= 1'b1;
    end else begin
      state <= state_n;
      tcnt  <= tcnt_n;
      bcnt  <= bcnt_n;
      sh    <= sh_n;
      data  <= data_n;
      valid <= valid_n;
      perr  <= perr_n;
      ferr  <= ferr_n;
      rx_d  <= rxd;
    end
  end

  assign rx.data   = data;
  assign rx.valid  = valid;
  assign rx.perror = perr;
  assign rx.ferror = ferr;

endmodule

// File: rtl/uart_receiver.sv
// UART receiver top: input synchronizer,
// baud tick generator and frame FSM.
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       Rx_EN,
  input  logic       RxD,
  output logic [7:0] Rx_DATA,
  output logic       Rx_VALID,
  output logic       Rx_PERROR,
  output logic       Rx_FERROR
);

  logic s1, s2;
  logic sample_tick;

  uart_receiver_if rx_bus ();

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= RxD;
      s2 <= s1;
    end
  end

  baud_controller #(
    .CLK_HZ     (CLK_HZ),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_baud (
    .clk         (clk),
    .reset       (reset),
    .baud_select (baud_select),
    .sample_tick (sample_tick)
  );

  uart_receiver_fsm #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_fsm (
    .clk         (clk),
    .reset       (reset),
    .sample_tick (sample_tick),
    .rx_en       (Rx_EN),
    .rxd         (s2),
    .rx          (rx_bus.master)
  );

  assign Rx_DATA   = rx_bus.data;
  assign Rx_VALID  = rx_bus.valid;
  assign Rx_PERROR = rx_bus.perror;
  assign Rx_FERROR = rx_bus.ferror;

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: directed
// frames queue expected bytes, a monitor pops on Rx_VALID.
module tb_uart_receiver;

  // 7.3728 MHz gives divisors 4 (sel 7) and 24 (sel 4).
  localparam int unsigned CLK_HZ = 7372800;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] baud_select = 3'd7;
  logic       Rx_EN = 1'b1;
  logic       RxD = 1'b1;

  uart_receiver_if mon ();

  uart_receiver #(
    .CLK_HZ     (CLK_HZ),
    .OVERSAMPLE (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .baud_select (baud_select),
    .Rx_EN       (Rx_EN),
    .RxD         (RxD),
    .Rx_DATA     (mon.data),
    .Rx_VALID    (mon.valid),
    .Rx_PERROR   (mon.perror),
    .Rx_FERROR   (mon.ferror)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  int         bit_clks = 64;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon.valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got data %0h expected no pulse",
                 mon.data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("rx_data_on_valid", int'(mon.data), int'(mon_exp));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_baud(input logic [2:0] sel, input int div);
    @(negedge clk);
    baud_select = sel;
    bit_clks = 16 * div;
    idle(8 * bit_clks);
  endtask

  // mode 0 normal, 1 drop Rx_EN at data bit 3, 2 reset at data bit 4.
  task automatic send_frame(input logic [7:0] b, input logic par,
                            input logic stp, input int mode);
    logic [10:0] frame;
    frame = {stp, par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      RxD = frame[i];
      if (mode == 1 && i == 4) Rx_EN = 1'b0;
      if (mode == 2 && i == 5) reset = 1'b0;
      repeat (bit_clks - 1) @(negedge clk);
    end
    @(negedge clk);
    RxD = 1'b1;
    if (mode == 1) Rx_EN = 1'b1;
    if (mode == 2) begin
      idle(4);
      reset = 1'b1;
    end
  endtask

  task automatic meas_div(input string name, input int exp);
    int cyc;
    int first;
    int second;
    cyc = 0;
    first = -1;
    second = -1;
    while (cyc < 200 && second < 0) begin
      @(posedge clk);
      #1;
      cyc++;
      if (dut.sample_tick === 1'b1) begin
        if (first < 0) first = cyc;
        else second = cyc;
      end
    end
    check(name, (second < 0) ? -1 : second - first, exp);
  endtask

  task automatic check_out(input string tag, input logic [7:0] d,
                           input logic pe, input logic fe);
    @(negedge clk);
    check({tag, "_data"}, int'(mon.data), int'(d));
    check({tag, "_perror"}, int'(mon.perror), int'(pe));
    check({tag, "_ferror"}, int'(mon.ferror), int'(fe));
    check({tag, "_pending"}, exp_q.size(), 0);
  endtask

  initial begin
    idle(5);
    check_out("reset", 8'h00, 1'b0, 1'b0);
    check("reset_valid", int'(mon.valid), 0);
    reset = 1'b1;
    idle(20);

    set_baud(3'd7, 4);
    meas_div("div_sel7", 4);

    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b0, 1'b1, 0);
    idle(20);
    check_out("good_55", 8'h55, 1'b0, 1'b0);

    send_frame(8'hA3, 1'b1, 1'b1, 0);
    idle(20);
    check_out("parity_A3", 8'h55, 1'b1, 1'b0);

    set_baud(3'd4, 24);
    meas_div("div_sel4", 24);

    send_frame(8'h0F, 1'b0, 1'b0, 0);
    idle(2 * bit_clks);
    check_out("frame_0F", 8'h55, 1'b0, 1'b1);

    exp_q.push_back(8'hF0);
    send_frame(8'hF0, 1'b0, 1'b1, 0);
    idle(20);
    check_out("good_F0", 8'hF0, 1'b0, 1'b0);

    set_baud(3'd7, 4);
    @(negedge clk);
    RxD = 1'b0;
    idle(12);
    RxD = 1'b1;
    idle(3 * bit_clks);
    check_out("glitch", 8'hF0, 1'b0, 1'b0);

    send_frame(8'h12, 1'b0, 1'b1, 1);
    idle(2 * bit_clks);
    check_out("rx_en_drop", 8'hF0, 1'b0, 1'b0);

    send_frame(8'hA3, 1'b1, 1'b1, 0);
    idle(20);
    check_out("parity_A3b", 8'hF0, 1'b1, 1'b0);

    send_frame(8'h81, 1'b0, 1'b1, 2);
    idle(2 * bit_clks);
    check_out("mid_reset", 8'h00, 1'b0, 1'b0);

    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b0, 1'b1, 0);
    idle(20);
    check_out("good_81", 8'h81, 1'b0, 1'b0);

    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h3C);
    send_frame(8'h00, 1'b0, 1'b1, 0);
    send_frame(8'hFF, 1'b0, 1'b1, 0);
    send_frame(8'h3C, 1'b0, 1'b1, 0);
    idle(20);
    check_out("b2b_3C", 8'h3C, 1'b0, 1'b0);

    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1, 0);
    idle(20);
    check_out("good_07", 8'h07, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
